param_fetch: RTL and testbench

PARAM_FETCH -- requirements
Module: param_fetch

---
 rtl/param_fetch_if.sv | 37 +++
 rtl/param_fetch.sv | 119 +++++++++++
 tb/tb_param_fetch.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/param_fetch_if.sv
// Bundle of the parameter-fetch ports: batch control, the shared read port of the
// record/state files and the downstream ready/valid record channel.
interface param_fetch_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int POS_W  = 4
);
  logic                start;
  logic [ADDR_W-1:0]   base_addr;
  logic [ADDR_W:0]     num_entries;
  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr;
  logic [4*DATA_W-1:0] rec_rd_data;
  logic [POS_W:0]      st_rd_data;
  logic [DATA_W-1:0]   i_out;
  logic [DATA_W-1:0]   z_out;
  logic [DATA_W-1:0]   k_out;
  logic [DATA_W-1:0]   l_out;
  logic [POS_W-1:0]    position;
  logic                out_valid;
  logic                out_ready;
  logic                busy;
  logic                current_finish;
  logic [ADDR_W:0]     skip_cnt;

  modport master (
    input  start, base_addr, num_entries, rec_rd_data, st_rd_data, out_ready,
    output rd_en, rd_addr, i_out, z_out, k_out, l_out, position, out_valid,
           busy, current_finish, skip_cnt
  );

  modport slave (
    output start, base_addr, num_entries, rec_rd_data, st_rd_data, out_ready,
    input  rd_en, rd_addr, i_out, z_out, k_out, l_out, position, out_valid,
           busy, current_finish, skip_cnt
  );
endinterface

// File: rtl/param_fetch.sv
// Walks a batch of records, reading record and state files in lockstep, skipping
// inactive entries and presenting each active record on a ready/valid channel.
module param_fetch #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int POS_W  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  param_fetch_if.master bus
);

  typedef enum logic [2:0] {IDLE, READ, CAPTURE, OUT, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_W-1:0]       base_reg, base_next;
  logic [ADDR_W:0]         count_reg, count_next;
  logic [ADDR_W:0]         index_reg, index_next;
  logic [ADDR_W:0]         skip_reg, skip_next;
  logic [ADDR_W-1:0]       rd_addr_reg, rd_addr_next;
  logic [3:0][DATA_W-1:0]  field_reg, field_next;
  logic [POS_W-1:0]        pos_reg, pos_next;
  logic                    valid_reg, valid_next;

  logic [ADDR_W:0]         index_inc;
  logic [ADDR_W-1:0]       cur_addr;
  logic                    active;

  assign index_inc = index_reg + {{ADDR_W{1'b0}}, 1'b1};
  // Truncation to ADDR_W bits gives the wrap past the top of the file.
  assign cur_addr  = base_reg + index_reg[ADDR_W-1:0];
  assign active    = bus.st_rd_data[POS_W];

  always_comb begin
    state_next   = state_reg;
    base_next    = base_reg;
    count_next   = count_reg;
    index_next   = index_reg;
    skip_next    = skip_reg;
    rd_addr_next = rd_addr_reg;
    field_next   = field_reg;
    pos_next     = pos_reg;
    valid_next   = valid_reg;
    unique case (state_reg)
      IDLE: begin
        if (bus.start) begin
          base_next  = bus.base_addr;
          count_next = bus.num_entries;
          index_next = '0;
          skip_next  = '0;
          state_next = (bus.num_entries == '0) ? DONE : READ;
        end
      end
      READ: begin
        rd_addr_next = cur_addr;
        state_next   = CAPTURE;
      end
      CAPTURE: begin
        if (active) begin
          field_next = bus.rec_rd_data;
          pos_next   = bus.st_rd_data[POS_W-1:0];
          valid_next = 1'b1;
          state_next = OUT;
        end else begin
          skip_next  = skip_reg + {{ADDR_W{1'b0}}, 1'b1};
          index_next = index_inc;
          state_next = (index_inc < count_reg) ? READ : DONE;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          valid_next = 1'b0;
          index_next = index_inc;
          state_next = (index_inc < count_reg) ? READ : DONE;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      base_reg    <= '0;
      count_reg   <= '0;
      index_reg   <= '0;
      skip_reg    <= '0;
      rd_addr_reg <= '0;
      field_reg   <= '0;
      pos_reg     <= '0;
      valid_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      base_reg    <= base_next;
      count_reg   <= count_next;
      index_reg   <= index_next;
      skip_reg    <= skip_next;
      rd_addr_reg <= rd_addr_next;
      field_reg   <= field_next;
      pos_reg     <= pos_next;
      valid_reg   <= valid_next;
    end
  end

  // Address is live during READ and otherwise shows the last address issued.
  assign bus.rd_en          = (state_reg == READ);
  assign bus.rd_addr        = (state_reg == READ) ? cur_addr : rd_addr_reg;
  assign bus.i_out          = field_reg[3];
  assign bus.z_out          = field_reg[2];
  assign bus.k_out          = field_reg[1];
  assign bus.l_out          = field_reg[0];
  assign bus.position       = pos_reg;
  assign bus.out_valid      = valid_reg;
  assign bus.busy           = (state_reg != IDLE);
  assign bus.current_finish = (state_reg == DONE);
  assign bus.skip_cnt       = skip_reg;

endmodule

// File: tb/tb_param_fetch.sv
// Randomized bench for param_fetch: file models answer reads, and a batch-level
// reference list of addresses, records and skips is compared against what was observed.
`timescale 1ns/1ps
module tb_param_fetch;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;
  localparam int POS_W  = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  param_fetch_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .POS_W(POS_W)) bus ();

  param_fetch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .POS_W(POS_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [4*DATA_W-1:0] rec_mem [DEPTH];
  logic [POS_W:0]      st_mem  [DEPTH];

  int checks = 0;
  int errors = 0;

  int          addr_q [$];
  logic [35:0] out_q  [$];
  int fin_cnt, fin_cyc, first_rd, first_ov, overlap, stall_viol;
  int cyc = 0;
  int start_cyc;
  int ready_mode = 0;  // 0 high, 1 random, 3 driven by the test
  bit prev_stall = 1'b0;
  logic [35:0] prev_out, mon_cur;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] cur_out();
    return {bus.i_out, bus.z_out, bus.k_out, bus.l_out, bus.position};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Record and state files with one-cycle registered read.
  initial forever begin
    @(posedge clk);
    if (bus.rd_en) begin
      bus.rec_rd_data <= rec_mem[bus.rd_addr];
      bus.st_rd_data  <= st_mem[bus.rd_addr];
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (ready_mode == 0) bus.out_ready = 1'b1;
    else if (ready_mode == 1) bus.out_ready = ($urandom_range(0, 2) != 0);
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      mon_cur = cur_out();
      if (bus.rd_en) begin
        addr_q.push_back(int'(bus.rd_addr));
        if (first_rd < 0) first_rd = cyc;
      end
      if (bus.out_valid && first_ov < 0) first_ov = cyc;
      if (bus.out_valid && bus.out_ready) out_q.push_back(mon_cur);
      if (bus.current_finish) begin
        fin_cnt++;
        fin_cyc = cyc;
      end
      if (bus.rd_en && bus.out_valid) overlap++;
      if (prev_stall && (!bus.out_valid || mon_cur !== prev_out)) stall_viol++;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out   = mon_cur;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic clear_monitor();
    addr_q.delete();
    out_q.delete();
    fin_cnt = 0; fin_cyc = -1; first_rd = -1; first_ov = -1;
    overlap = 0; stall_viol = 0;
  endtask

  task automatic run_batch(input int base, input int n, input int mode,
                           input bit do_stall, input bit extra_start);
    int          exp_addr [$];
    logic [35:0] exp_out  [$];
    int          exp_skip = 0;
    int          a, waited;
    bit          got;
    logic [35:0] snap;
    for (int j = 0; j < n; j++) begin
      a = (base + j) % DEPTH;
      exp_addr.push_back(a);
      if (st_mem[a][POS_W]) exp_out.push_back({rec_mem[a], st_mem[a][POS_W-1:0]});
      else exp_skip++;
    end
    clear_monitor();
    ready_mode = do_stall ? 3 : mode;
    if (do_stall) bus.out_ready = 1'b0;

    @(posedge clk); #1;
    bus.start = 1'b1; bus.base_addr = ADDR_W'(base); bus.num_entries = (ADDR_W+1)'(n);
    @(posedge clk); #1;
    start_cyc = cyc;
    bus.start = 1'b0; bus.base_addr = ADDR_W'($urandom); bus.num_entries = (ADDR_W+1)'($urandom);
    check("busy_after_start", bus.busy, 1);

    if (do_stall) begin
      got = 1'b0;
      for (int w = 0; w < 20 && !got; w++) begin
        @(negedge clk);
        if (bus.out_valid) got = 1'b1;
      end
      check("stall_valid_seen", got, 1);
      snap = cur_out();
      repeat (5) begin
        @(negedge clk);
        check("stall_valid", bus.out_valid, 1);
        check("stall_data", cur_out(), snap);
        check("stall_no_rd", bus.rd_en, 0);
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      ready_mode = mode;
    end

    waited = 0;
    while (fin_cnt == 0 && waited < 2000) begin
      @(negedge clk);
      waited++;
      if (extra_start && waited == 3) begin
        bus.start = 1'b1;
        bus.base_addr = ADDR_W'($urandom);
        bus.num_entries = (ADDR_W+1)'($urandom_range(1, DEPTH));
      end
      if (extra_start && waited == 4) bus.start = 1'b0;
    end
    bus.start = 1'b0;
    repeat (3) @(negedge clk);

    check("finish_count", fin_cnt, 1);
    check("busy_end", bus.busy, 0);
    check("skip_cnt", bus.skip_cnt, exp_skip);
    check("rd_count", addr_q.size(), exp_addr.size());
    for (int j = 0; j < exp_addr.size() && j < addr_q.size(); j++)
      check($sformatf("rd_addr[%0d]", j), addr_q[j], exp_addr[j]);
    check("out_count", out_q.size(), exp_out.size());
    for (int j = 0; j < exp_out.size() && j < out_q.size(); j++)
      check($sformatf("out_rec[%0d]", j), out_q[j], exp_out[j]);
    check("rd_during_valid", overlap, 0);
    check("stall_stability", stall_viol, 0);
    check("valid_after_batch", bus.out_valid, 0);
    if (exp_out.size() > 0) check("retain_last", cur_out(), exp_out[exp_out.size()-1]);
    if (n > 0) check("rd_latency", first_rd - start_cyc, 0);
    if (n > 0 && st_mem[base % DEPTH][POS_W]) check("valid_latency", first_ov - start_cyc, 2);
    if (mode == 0 && !do_stall)
      check("duration", fin_cyc - start_cyc, 3 * exp_out.size() + 2 * exp_skip);
    $display("batch base=%0d n=%0d mode=%0d stall=%0d outs=%0d skips=%0d", base, n, mode,
             do_stall, out_q.size(), bus.skip_cnt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.base_addr = '0; bus.num_entries = '0;
    bus.out_ready = 1'b1; bus.rec_rd_data = '0; bus.st_rd_data = '0;
    for (int a = 0; a < DEPTH; a++) begin
      rec_mem[a] = $urandom;
      st_mem[a]  = {($urandom_range(0, 9) < 7), 4'($urandom)};
    end
    clear_monitor();

    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.num_entries = 7'd3;
    @(posedge clk); #1;
    check("rst_rd_en", bus.rd_en, 0);
    check("rst_rd_addr", bus.rd_addr, 0);
    check("rst_i", bus.i_out, 0);
    check("rst_z", bus.z_out, 0);
    check("rst_k", bus.k_out, 0);
    check("rst_l", bus.l_out, 0);
    check("rst_position", bus.position, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_finish", bus.current_finish, 0);
    check("rst_skip", bus.skip_cnt, 0);
    bus.start = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_after_release", bus.busy, 0);
    $display("reset checks done");

    for (int a = 5; a < 8; a++) st_mem[a][POS_W] = 1'b1;
    run_batch(5, 3, 0, 0, 0);

    st_mem[30][POS_W] = 1'b1; st_mem[31][POS_W] = 1'b0;
    st_mem[32][POS_W] = 1'b1; st_mem[33][POS_W] = 1'b0;
    run_batch(30, 4, 0, 0, 0);

    run_batch(62, 4, 0, 0, 0);
    run_batch(17, 0, 0, 0, 0);

    st_mem[20][POS_W] = 1'b1; st_mem[21][POS_W] = 1'b1;
    run_batch(20, 2, 0, 1, 0);

    run_batch(int'($urandom_range(0, DEPTH-1)), DEPTH, 0, 0, 0);
    for (int t = 0; t < 10; t++)
      run_batch(int'($urandom_range(0, DEPTH-1)), int'($urandom_range(1, 12)),
                int'($urandom_range(0, 1)), 0, (t % 2 == 0));
    run_batch(50, 6, 1, 0, 1);

    // Reset while a record is stalled in OUT.
    st_mem[40][POS_W] = 1'b1;
    clear_monitor();
    ready_mode = 3; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.base_addr = 6'd40; bus.num_entries = 7'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_stalled", bus.out_valid, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_valid", bus.out_valid, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_rd_en", bus.rd_en, 0);
    check("abort_rd_addr", bus.rd_addr, 0);
    check("abort_data", cur_out(), 0);
    check("abort_skip", bus.skip_cnt, 0);
    check("abort_finish", bus.current_finish, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1; ready_mode = 0;
    clear_monitor();
    repeat (6) @(negedge clk);
    check("post_abort_rd", addr_q.size(), 0);
    check("post_abort_finish", fin_cnt, 0);
    check("post_abort_busy", bus.busy, 0);
    $display("reset abort checks done");

    run_batch(9, 5, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
